jt49_noise_gen: RTL and testbench

Parametrised noise generator for the JT49-family PSG cores: a programmable cen-driven divider clocks an LFSR of configurable length and tap. The block adds periodic (rotate) mode, seed reload and a shift strobe. It sits beside the tone channels and feeds the mixer's noise enable path. One instance serves AY-3-8910/YM2149 noise (defaults) or SN76489-style noise (LW=15/16, periodic mode).

---
 rtl/jt49_noise_pkg.sv | 23 ++
 rtl/jt49_noise_div.sv | 51 +++++
 rtl/jt49_noise_gen.sv | 89 ++++++++
 tb/tb_jt49_noise_gen.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jt49_noise_pkg.sv
// ============================================================================
//  Module      : jt49_noise_pkg
//  Description : Shared constants for the JT49 noise generator.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package jt49_noise_pkg;

    localparam logic NOISE_WHITE    = 1'b0;
    localparam logic NOISE_PERIODIC = 1'b1;

    // LFSR length / second tap pairs for the supported chip families
    localparam int AY_LW           = 17;
    localparam int AY_TAP          = 3;
    localparam int SN_WHITE_LW     = 15;
    localparam int SN_WHITE_TAP    = 1;
    localparam int SN_PERIODIC_LW  = 15;
    localparam int SN_PERIODIC_TAP = 1;

endpackage

`default_nettype wire

// File: rtl/jt49_noise_div.sv
// ============================================================================
//  Module      : jt49_noise_div
//  Description : cen-driven programmable divider; div toggles every p_eff cens.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jt49_noise_div
    import jt49_noise_pkg::*;
#(
    parameter int PW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_cen,
    input  logic [PW-1:0] i_period,
    output logic          o_div
);

    logic [PW-1:0] r_cnt;
    logic          r_div;
    logic [PW-1:0] w_p_eff;
    logic [PW-1:0] w_last;
    logic          w_wrap;

    // ">=" rather than "==" so a period lowered mid-count wraps on the next cen
    always_comb begin
        w_p_eff = (i_period == '0) ? PW'(1) : i_period;
        w_last  = w_p_eff - PW'(1);
        w_wrap  = (r_cnt >= w_last);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_div <= 1'b0;
        end else if (i_cen) begin
            if (w_wrap) begin
                r_cnt <= '0;
                r_div <= ~r_div;
            end else begin
                r_cnt <= r_cnt + PW'(1);
            end
        end
    end

    assign o_div = r_div;

endmodule

`default_nettype wire

// File: rtl/jt49_noise_gen.sv
// ============================================================================
//  Module      : jt49_noise_gen
//  Description : Parametrised PSG noise generator (white / periodic LFSR).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jt49_noise_gen
    import jt49_noise_pkg::*;
#(
    parameter int            PW   = 5,
    parameter int            LW   = AY_LW,
    parameter int            TAP  = AY_TAP,
    parameter logic [LW-1:0] SEED = LW'(1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic [PW-1:0] period,
    input  logic          mode,
    input  logic          load,
    output logic          noise,
    output logic          shift,
    output logic [LW-1:0] lfsr
);

    if (LW < 4 || LW > 32) begin : g_bad_lw
        $error("jt49_noise_gen: LW must be in 4..32");
    end
    if (TAP < 1 || TAP > LW - 1) begin : g_bad_tap
        $error("jt49_noise_gen: TAP must be in 1..LW-1");
    end

    logic          w_div;
    logic          r_last_div;
    logic [LW-1:0] r_lfsr;
    logic          r_noise;
    logic          r_shift;
    logic          w_up;
    logic          w_zero;
    logic          w_fb;
    logic          w_step;

    jt49_noise_div #(
        .PW (PW)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_cen    (cen),
        .i_period (period),
        .o_div    (w_div)
    );

    // The zero term lets an all-zero register escape lock-up in either mode
    always_comb begin
        w_up   = w_div & ~r_last_div;
        w_zero = (r_lfsr == '0);
        w_fb   = (mode == NOISE_PERIODIC) ? (r_lfsr[0] | w_zero)
                                          : (r_lfsr[0] ^ r_lfsr[TAP] ^ w_zero);
        w_step = cen & w_up & ~load;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_div <= 1'b0;
            r_lfsr     <= '0;
            r_noise    <= 1'b1;
            r_shift    <= 1'b0;
        end else begin
            r_shift <= w_step;
            if (cen) begin
                r_last_div <= w_div;
                r_noise    <= ~r_lfsr[0];
                if (load) begin
                    r_lfsr <= SEED;
                end else if (w_up) begin
                    r_lfsr <= {w_fb, r_lfsr[LW-1:1]};
                end
            end
        end
    end

    assign noise = r_noise;
    assign shift = r_shift;
    assign lfsr  = r_lfsr;

endmodule

`default_nettype wire

// File: tb/tb_jt49_noise_gen.sv
// ============================================================================
//  Module      : tb_jt49_noise_gen
//  Description : Directed self-checking bench for jt49_noise_gen (defaults).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jt49_noise_gen;

    logic        clk;
    logic        rst_n;
    logic        cen;
    logic [4:0]  period;
    logic        mode;
    logic        load;
    logic        noise;
    logic        shift;
    logic [16:0] lfsr;

    int n_checks;
    int n_pass;

    jt49_noise_gen dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .cen    (cen),
        .period (period),
        .mode   (mode),
        .load   (load),
        .noise  (noise),
        .shift  (shift),
        .lfsr   (lfsr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] nstep(input logic [16:0] s, input logic per);
        logic z;
        z = (s == 17'd0);
        if (per) return {s[0] | z, s[16:1]};
        else     return {s[0] ^ s[3] ^ z, s[16:1]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cen   = 1'b0;
        load  = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        period = 5'd1;
        mode   = 1'b0;
        do_reset();
        n_checks++;
        if (lfsr !== 17'h0 || noise !== 1'b1 || shift !== 1'b0)
            $display("FAIL reset: lfsr=%h noise=%b shift=%b, want lfsr=00000 noise=1 shift=0",
                     lfsr, noise, shift);
        else n_pass++;
    endtask

    task automatic test_first_shift();
        logic [16:0] exp_l [4];
        logic        exp_s [4];
        exp_l = '{17'h00000, 17'h10000, 17'h10000, 17'h08000};
        exp_s = '{1'b0, 1'b1, 1'b0, 1'b1};
        period = 5'd1;
        mode   = 1'b0;
        do_reset();
        cen = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_checks++;
            if (lfsr !== exp_l[c] || shift !== exp_s[c])
                $display("FAIL first_shift cen%0d: lfsr=%h shift=%b, want lfsr=%h shift=%b",
                         c + 1, lfsr, shift, exp_l[c], exp_s[c]);
            else n_pass++;
        end
        cen = 1'b0;
    endtask

    task automatic test_white_seq();
        logic [16:0] m;
        logic        exp_n;
        logic        exp_s;
        period = 5'd1;
        mode   = 1'b0;
        do_reset();
        m   = 17'h0;
        cen = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            exp_n = ~m[0];
            exp_s = (c % 2 == 0);
            if (exp_s) m = nstep(m, 1'b0);
            tick();
            n_checks++;
            if (lfsr !== m || noise !== exp_n || shift !== exp_s || (c >= 2 && lfsr == 17'h0))
                $display("FAIL white_seq cen%0d: lfsr=%h noise=%b shift=%b, want lfsr=%h noise=%b shift=%b",
                         c, lfsr, noise, shift, m, exp_n, exp_s);
            else n_pass++;
        end
        cen = 1'b0;
    endtask

    task automatic test_period3();
        int c;
        logic exp_s;
        period = 5'd3;
        mode   = 1'b0;
        do_reset();
        c = 0;
        for (int i = 0; i < 88; i++) begin
            cen = (i % 4 == 3);
            tick();
            if (cen) c++;
            exp_s = cen && (c >= 4) && ((c - 4) % 6 == 0);
            n_checks++;
            if (shift !== exp_s)
                $display("FAIL period3 clk%0d (cen%0d): shift=%b, want %b", i, c, shift, exp_s);
            else n_pass++;
        end
        cen = 1'b0;
    endtask

    task automatic test_periodic();
        logic [16:0] exp_l;
        period = 5'd1;
        mode   = 1'b1;
        do_reset();
        cen = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (k == 18) begin
                n_checks++;
                if (noise !== 1'b0)
                    $display("FAIL periodic noise after shift17: noise=%b, want 0", noise);
                else n_pass++;
            end
            tick();
            exp_l = (k <= 17) ? (17'h1 << (17 - k)) : 17'h10000;
            n_checks++;
            if (lfsr !== exp_l || shift !== 1'b1)
                $display("FAIL periodic shift%0d: lfsr=%h shift=%b, want lfsr=%h shift=1",
                         k, lfsr, shift, exp_l);
            else n_pass++;
            if (k == 17) begin
                n_checks++;
                if (noise !== 1'b1)
                    $display("FAIL periodic noise at shift17: noise=%b, want 1", noise);
                else n_pass++;
            end
        end
        cen  = 1'b0;
        mode = 1'b0;
    endtask

    task automatic test_load();
        period = 5'd1;
        mode   = 1'b0;
        do_reset();
        cen = 1'b1;
        tick();
        load = 1'b1;
        tick();
        load = 1'b0;
        n_checks++;
        if (lfsr !== 17'h00001 || shift !== 1'b0)
            $display("FAIL load: lfsr=%h shift=%b, want lfsr=00001 shift=0", lfsr, shift);
        else n_pass++;
        tick();
        n_checks++;
        if (lfsr !== 17'h00001 || shift !== 1'b0)
            $display("FAIL load_gap: lfsr=%h shift=%b, want lfsr=00001 shift=0", lfsr, shift);
        else n_pass++;
        tick();
        n_checks++;
        if (lfsr !== 17'h10000 || shift !== 1'b1)
            $display("FAIL load_next_shift: lfsr=%h shift=%b, want lfsr=10000 shift=1", lfsr, shift);
        else n_pass++;
        cen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (lfsr !== 17'h10000 || shift !== 1'b0 || noise !== 1'b0)
                $display("FAIL cen_hold clk%0d: lfsr=%h shift=%b noise=%b, want lfsr=10000 shift=0 noise=0",
                         i, lfsr, shift, noise);
            else n_pass++;
        end
    endtask

    task automatic test_period_change_and_reset();
        logic exp_s;
        period = 5'd31;
        mode   = 1'b0;
        do_reset();
        cen = 1'b1;
        for (int c = 1; c <= 20; c++) tick();
        n_checks++;
        if (shift !== 1'b0 || lfsr !== 17'h0)
            $display("FAIL pchg_pre: shift=%b lfsr=%h, want shift=0 lfsr=00000", shift, lfsr);
        else n_pass++;
        period = 5'd2;
        for (int c = 21; c <= 30; c++) begin
            tick();
            exp_s = (c >= 22) && ((c - 22) % 4 == 0);
            n_checks++;
            if (shift !== exp_s)
                $display("FAIL pchg cen%0d: shift=%b, want %b", c, shift, exp_s);
            else n_pass++;
        end
        rst_n = 1'b0;
        cen   = 1'b0;
        tick();
        n_checks++;
        if (lfsr !== 17'h0 || noise !== 1'b1 || shift !== 1'b0)
            $display("FAIL mid_reset: lfsr=%h noise=%b shift=%b, want lfsr=00000 noise=1 shift=0",
                     lfsr, noise, shift);
        else n_pass++;
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        cen      = 1'b0;
        period   = 5'd1;
        mode     = 1'b0;
        load     = 1'b0;
        test_reset();
        test_first_shift();
        test_white_seq();
        test_period3();
        test_periodic();
        test_load();
        test_period_change_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
